// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared state encoding and default sizes for the CPU clock run/step/halt controller.
package cpu_clk_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_HALT = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } state_t;

   localparam int          DIV_W_DEFAULT    = 32;
   localparam int          CNT_W_DEFAULT    = 32;
   // 500 Hz tick from the 50 MHz source
   localparam int unsigned DEFAULT_DIV_INIT = 100000;

endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// Control/status bundle between the board-side controls (master) and cpu_clk_ctrl (slave).
interface cpu_clk_ctrl_if
   import cpu_clk_ctrl_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEFAULT,
   parameter int CNT_W = CNT_W_DEFAULT
) ();

   logic             i_run;
   logic             i_step;
   logic             i_halt;
   logic             i_div_wr;
   logic [DIV_W-1:0] i_div_data;

   logic             o_tick;
   logic             o_cpu_clk;
   logic             o_busy;
   state_t           o_state;
   logic [CNT_W-1:0] o_cycle_count;

   modport master (
      output i_run,
      output i_step,
      output i_halt,
      output i_div_wr,
      output i_div_data,
      input  o_tick,
      input  o_cpu_clk,
      input  o_busy,
      input  o_state,
      input  o_cycle_count
   );

   modport slave (
      input  i_run,
      input  i_step,
      input  i_halt,
      input  i_div_wr,
      input  i_div_data,
      output o_tick,
      output o_cpu_clk,
      output o_busy,
      output o_state,
      output o_cycle_count
   );

endinterface

// File: rtl/clk_tick_div.sv
// Programmable divider: holds the divisor and count, flags the terminal count and
// registers the one-cycle tick and the toggling cpu_clk.
module clk_tick_div
   import cpu_clk_ctrl_pkg::*;
#(
   parameter int               DIV_W       = DIV_W_DEFAULT,
   parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(DEFAULT_DIV_INIT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_enable,
   input  logic             i_clear,
   input  logic             i_div_wr,
   input  logic [DIV_W-1:0] i_div_data,
   output logic             o_tc,
   output logic             o_tick,
   output logic             o_cpu_clk
);

   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_count;
   logic [DIV_W-1:0] w_div_eff;
   logic [DIV_W-1:0] w_last;
   logic             w_at_last;
   logic             r_tick;
   logic             r_cpu_clk;

   // A zero divisor behaves as one so the count always has a reachable end
   assign w_div_eff = (r_div == '0) ? DIV_W'(1) : r_div;
   assign w_last    = w_div_eff - DIV_W'(1);
   assign w_at_last = (r_count == w_last);

   // A divisor write wins over the terminal count, suppressing that tick
   assign o_tc = i_enable & ~i_clear & ~i_div_wr & w_at_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div     <= DEFAULT_DIV;
         r_count   <= '0;
         r_tick    <= 1'b0;
         r_cpu_clk <= 1'b0;
      end else begin
         r_tick <= o_tc;
         if (o_tc) begin
            r_cpu_clk <= ~r_cpu_clk;
         end
         if (i_div_wr) begin
            r_div <= i_div_data;
         end
         if (i_div_wr || !i_enable || i_clear || w_at_last) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + DIV_W'(1);
         end
      end
   end

   assign o_tick    = r_tick;
   assign o_cpu_clk = r_cpu_clk;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt controller for the CPU clock enable. Optional cycle counter is built
// only when CPU_CLK_CTRL_CYCLE_COUNT_EN is defined; otherwise cycle_count reads 0.
module cpu_clk_ctrl
   import cpu_clk_ctrl_pkg::*;
#(
   parameter int               DIV_W       = DIV_W_DEFAULT,
   parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(DEFAULT_DIV_INIT),
   parameter int               CNT_W       = CNT_W_DEFAULT
) (
   input  logic          clksrc,
   input  logic          rst_n,
   cpu_clk_ctrl_if.slave bus
);

   state_t r_state;
   state_t w_state_next;
   logic   r_step_q;
   logic   r_busy;
   logic   r_entered;
   logic   w_step_rise;
   logic   w_cnt_en;
   logic   w_tc;
   logic   w_tick;
   logic   w_cpu_clk;

   assign w_step_rise = bus.i_step & ~r_step_q;

   // Count only on edges where the FSM stays in RUN/STEP, so leaving never ticks
   assign w_cnt_en = ~bus.i_halt &
                     (((r_state == ST_RUN) & bus.i_run) | (r_state == ST_STEP));

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_HALT: begin
            if (bus.i_halt) begin
               w_state_next = ST_HALT;
            end else if (bus.i_run) begin
               w_state_next = ST_RUN;
            end else if (w_step_rise) begin
               w_state_next = ST_STEP;
            end
         end
         ST_RUN: begin
            if (bus.i_halt || !bus.i_run) begin
               w_state_next = ST_HALT;
            end
         end
         ST_STEP: begin
            if (bus.i_halt || w_tc) begin
               w_state_next = ST_HALT;
            end
         end
         default: w_state_next = ST_HALT;
      endcase
   end

   always_ff @(posedge clksrc or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_HALT;
         r_step_q  <= 1'b0;
         r_busy    <= 1'b0;
         r_entered <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_step_q  <= bus.i_step;
         r_busy    <= (w_state_next == ST_STEP);
         // First cycle in RUN/STEP restarts the count, giving a 1+div_eff first-tick latency
         r_entered <= (w_state_next != r_state) && (w_state_next != ST_HALT);
      end
   end

   clk_tick_div #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_div (
      .clk        (clksrc),
      .rst_n      (rst_n),
      .i_enable   (w_cnt_en),
      .i_clear    (r_entered),
      .i_div_wr   (bus.i_div_wr),
      .i_div_data (bus.i_div_data),
      .o_tc       (w_tc),
      .o_tick     (w_tick),
      .o_cpu_clk  (w_cpu_clk)
   );

`ifdef CPU_CLK_CTRL_CYCLE_COUNT_EN
   logic [CNT_W-1:0] r_cycle_count;

   always_ff @(posedge clksrc or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle_count <= '0;
      end else if (w_tc) begin
         r_cycle_count <= r_cycle_count + CNT_W'(1);
      end
   end

   assign bus.o_cycle_count = r_cycle_count;
`else
   assign bus.o_cycle_count = {CNT_W{1'b0}};
`endif

   assign bus.o_tick    = w_tick;
   assign bus.o_cpu_clk = w_cpu_clk;
   assign bus.o_busy    = r_busy;
   assign bus.o_state   = r_state;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl: directed scenarios plus random stimulus against
// a tick-schedule reference model (next tick edge computed from divisor arithmetic).
module tb_cpu_clk_ctrl;

`ifdef CPU_CLK_CTRL_CYCLE_COUNT_EN
   localparam bit CC_EN = 1'b1;
`else
   localparam bit CC_EN = 1'b0;
`endif

   logic clksrc;
   logic rst_n;

   cpu_clk_ctrl_if #(.DIV_W(32), .CNT_W(32)) bus ();

   cpu_clk_ctrl dut (
      .clksrc (clksrc),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   initial begin
      clksrc = 1'b0;
      forever #5 clksrc = ~clksrc;
   end

   int n_checks;
   int n_bad;

   // Reference model: state 0=HALT 1=RUN 2=STEP, tick scheduled by absolute edge number
   int          m_state;
   longint      m_next;
   longint      edge_n;
   logic [31:0] m_div;
   bit          m_step_prev;
   bit          m_tick;
   bit          m_cpu_clk;
   logic [31:0] m_cycles;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic longint eff(input logic [31:0] d);
      return (d == 32'd0) ? 64'd1 : longint'(d);
   endfunction

   task automatic model_reset();
      m_state     = 0;
      m_next      = -1;
      m_div       = 32'd100000;
      m_step_prev = 1'b0;
      m_tick      = 1'b0;
      m_cpu_clk   = 1'b0;
      m_cycles    = 32'd0;
   endtask

   task automatic model_edge(input bit run, input bit step, input bit halt,
                             input bit wr, input logic [31:0] data);
      bit rise, stay, fire;
      int ns;
      rise = step && !m_step_prev;
      stay = (m_state == 1 && run && !halt) || (m_state == 2 && !halt);
      fire = stay && !wr && (edge_n == m_next);
      if (wr) m_div = data;
      ns = m_state;
      case (m_state)
         0: ns = halt ? 0 : (run ? 1 : (rise ? 2 : 0));
         1: ns = stay ? 1 : 0;
         default: ns = (halt || fire) ? 0 : 2;
      endcase
      if (m_state == 0 && ns != 0) m_next = edge_n + 1 + eff(m_div);
      else if (stay && wr)         m_next = edge_n + eff(m_div);
      else if (fire)               m_next = edge_n + eff(m_div);
      m_tick = fire;
      if (fire) begin
         m_cpu_clk = ~m_cpu_clk;
         m_cycles  = m_cycles + 32'd1;
      end
      m_state     = ns;
      m_step_prev = step;
      edge_n++;
   endtask

   task automatic check_outputs();
      check_eq("tick", bus.o_tick, m_tick);
      check_eq("cpu_clk", bus.o_cpu_clk, m_cpu_clk);
      check_eq("busy", bus.o_busy, m_state == 2);
      check_eq("state", bus.o_state, m_state);
      check_eq("cycle_count", bus.o_cycle_count, CC_EN ? m_cycles : 32'd0);
   endtask

   task automatic cycle(input bit run, input bit step, input bit halt,
                        input bit wr, input logic [31:0] data);
      @(negedge clksrc);
      bus.i_run      = run;
      bus.i_step     = step;
      bus.i_halt     = halt;
      bus.i_div_wr   = wr;
      bus.i_div_data = data;
      @(posedge clksrc);
      model_edge(run, step, halt, wr, data);
      #1;
      check_outputs();
   endtask

   task automatic do_reset(input string why);
      bus.i_run      = 1'b0;
      bus.i_step     = 1'b0;
      bus.i_halt     = 1'b0;
      bus.i_div_wr   = 1'b0;
      bus.i_div_data = 32'd0;
      rst_n = 1'b0;
      #1;
      $display("reset: %s", why);
      check_eq("rst_state", bus.o_state, 2'd0);
      check_eq("rst_tick", bus.o_tick, 1'b0);
      check_eq("rst_cpu_clk", bus.o_cpu_clk, 1'b0);
      check_eq("rst_busy", bus.o_busy, 1'b0);
      check_eq("rst_cycle_count", bus.o_cycle_count, 32'd0);
      model_reset();
      repeat (2) @(posedge clksrc);
      @(negedge clksrc);
      rst_n = 1'b1;
   endtask

   int exp4[4];
   int ticks[$];
   int n_tick;
   int gap;
   bit found;
   bit r_run;
   bit r_step;

   initial begin
      n_checks = 0;
      n_bad    = 0;
      edge_n   = 0;
      exp4     = '{5, 9, 13, 17};
      rst_n    = 1'b1;
      model_reset();
      #2;
      do_reset("power-on");

      $display("scenario: idle 200 cycles");
      repeat (200) cycle(0, 0, 0, 0, 0);

      $display("scenario: divisor 4, run 20 cycles");
      cycle(0, 0, 0, 1, 4);
      ticks.delete();
      for (int k = 0; k < 20; k++) begin
         cycle(1, 0, 0, 0, 0);
         if (bus.o_tick) ticks.push_back(k);
      end
      check_eq("run4_ntick", ticks.size(), 4);
      for (int i = 0; i < ticks.size() && i < 4; i++) check_eq("run4_tick_at", ticks[i], exp4[i]);
      check_eq("run4_cycle_count", bus.o_cycle_count, CC_EN ? 32'd4 : 32'd0);
      repeat (2) cycle(0, 0, 0, 0, 0);

      $display("scenario: divisor 3, step held 10 cycles");
      cycle(0, 0, 0, 1, 3);
      n_tick = 0;
      for (int k = 0; k < 10; k++) begin
         cycle(0, 1, 0, 0, 0);
         if (bus.o_tick) n_tick++;
      end
      check_eq("step_ntick", n_tick, 1);
      check_eq("step_end_state", bus.o_state, 2'd0);
      cycle(0, 0, 0, 0, 0);

      $display("scenario: divisor 5, halt pulse during run, run+halt together");
      cycle(0, 0, 0, 1, 5);
      repeat (4) cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 1, 0, 0);
      check_eq("halt_state", bus.o_state, 2'd0);
      check_eq("halt_tick", bus.o_tick, 1'b0);
      repeat (5) begin
         cycle(1, 0, 1, 0, 0);
         check_eq("runhalt_state", bus.o_state, 2'd0);
      end
      cycle(0, 0, 0, 0, 0);

      $display("scenario: divisor 0 written during run");
      cycle(0, 0, 0, 1, 2);
      repeat (4) cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 1, 0);
      n_tick = 0;
      for (int k = 0; k < 8; k++) begin
         cycle(1, 0, 0, 0, 0);
         if (bus.o_tick) n_tick++;
      end
      check_eq("div0_ntick", n_tick, 8);

      $display("scenario: divisor 6 written on a terminal-count edge");
      cycle(1, 0, 0, 1, 3);
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         if (m_state == 1 && m_next == edge_n) found = 1'b1;
         else cycle(1, 0, 0, 0, 0);
      end
      check_eq("div6_found", found, 1'b1);
      cycle(1, 0, 0, 1, 6);
      check_eq("div6_suppr", bus.o_tick, 1'b0);
      gap = 0;
      for (int k = 1; k <= 8; k++) begin
         cycle(1, 0, 0, 0, 0);
         if (bus.o_tick && gap == 0) gap = k;
      end
      check_eq("div6_gap", gap, 6);
      repeat (2) cycle(0, 0, 0, 0, 0);

      $display("scenario: random stimulus 3000 cycles");
      r_run  = 1'b0;
      r_step = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 19) == 0) r_run = ~r_run;
         if ($urandom_range(0, 3) == 0)  r_step = ~r_step;
         cycle(r_run, r_step, $urandom_range(0, 31) == 0,
               $urandom_range(0, 39) == 0, 32'($urandom_range(0, 7)));
      end
      repeat (2) cycle(0, 0, 0, 0, 0);

      $display("scenario: reset during step");
      cycle(0, 0, 0, 1, 50);
      cycle(0, 1, 0, 0, 0);
      repeat (3) cycle(0, 1, 0, 0, 0);
      check_eq("pre_rst_busy", bus.o_busy, 1'b1);
      #2;
      do_reset("mid-step");

      $display("scenario: reset with tick in flight");
      cycle(0, 0, 0, 1, 1);
      repeat (4) cycle(1, 0, 0, 0, 0);
      check_eq("pre_rst_tick", bus.o_tick, 1'b1);
      #2;
      do_reset("tick in flight");
      repeat (3) cycle(0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
